// File: rtl/fp_mul_normalize_pipe.sv
// Normalize, round-to-nearest-even and pack stage of the FP multiply pipeline (two stages, no backpressure).
// Optional status outputs (ovf/unf/inexact) are enabled by defining FP_MUL_NORM_STATUS_EN.
module fp_mul_normalize_pipe #(
  parameter int EXP_BIAS = 127,
  parameter int PASS_W   = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic [47:0]       M_mul,
  input  logic [7:0]        E_mul,
  input  logic [PASS_W-1:0] float_in_2,
  output logic [30:0]       float_out,
  output logic [PASS_W-1:0] float_out_2,
  output logic              ready
`ifdef FP_MUL_NORM_STATUS_EN
  ,
  output logic              ovf,
  output logic              unf,
  output logic              inexact
`endif
);

  localparam logic signed [9:0] BIAS_10 = 10'(EXP_BIAS);

  // Stage 1 next-state
  logic signed [9:0] e_ext;
  logic [22:0]       mant_d;
  logic              guard_d;
  logic              sticky_d;
  logic signed [9:0] exp_d;

  // Stage 1 registers
  logic              s1_vld_q;
  logic [22:0]       s1_mant_q;
  logic              s1_guard_q;
  logic              s1_sticky_q;
  logic signed [9:0] s1_exp_q;
  logic [PASS_W-1:0] s1_pass_q;

  // Stage 2 combinational
  logic              round_up;
  logic [23:0]       mant_sum;
  logic [22:0]       mant_r;
  logic signed [9:0] carry_ext;
  logic signed [9:0] exp_r;
  logic signed [9:0] be;
  logic              ovf_d;
  logic              unf_d;
  logic [30:0]       float_out_d;

  // Stage 2 registers
  logic [30:0]       float_out_q;
  logic [PASS_W-1:0] float_out_2_q;
  logic              ready_q;

  assign e_ext = {{2{E_mul[7]}}, E_mul};

  // An operand pair whose product lacks both top bits still takes the bit-46 path.
  // NOTE: every variable in an always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    mant_d   = M_mul[45:23];
    guard_d  = M_mul[22];
    sticky_d = |M_mul[21:0];
    exp_d    = e_ext;
    if (M_mul[47]) begin
      mant_d   = M_mul[46:24];
      guard_d  = M_mul[23];
      sticky_d = |M_mul[22:0];
      exp_d    = e_ext + 10'sd1;
    end
  end

  always_comb begin
    round_up    = s1_guard_q & (s1_sticky_q | s1_mant_q[0]);
    mant_sum    = {1'b0, s1_mant_q} + {23'd0, round_up};
    mant_r      = mant_sum[23] ? 23'd0 : mant_sum[22:0];
    carry_ext   = {9'd0, mant_sum[23]};
    exp_r       = s1_exp_q + carry_ext;
    be          = exp_r + BIAS_10;
    ovf_d       = (be >= 10'sd255);
    unf_d       = (be <= 10'sd0);
    float_out_d = {be[7:0], mant_r};
    if (ovf_d) begin
      float_out_d = {8'hFF, 23'd0};
    end else if (unf_d) begin
      float_out_d = 31'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: all pipeline data is reset as well, so a reset mid-stream leaves no stale result visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_mant_q   <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_exp_q    <= '0;
      s1_pass_q   <= '0;
    end else begin
      s1_vld_q <= valid;
      if (valid) begin
        s1_mant_q   <= mant_d;
        s1_guard_q  <= guard_d;
        s1_sticky_q <= sticky_d;
        s1_exp_q    <= exp_d;
        s1_pass_q   <= float_in_2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      float_out_q   <= '0;
      float_out_2_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      ready_q <= s1_vld_q;
      if (s1_vld_q) begin
        float_out_q   <= float_out_d;
        float_out_2_q <= s1_pass_q;
      end
    end
  end

  assign float_out   = float_out_q;
  assign float_out_2 = float_out_2_q;
  assign ready       = ready_q;

`ifdef FP_MUL_NORM_STATUS_EN
  logic ovf_q;
  logic unf_q;
  logic inexact_q;

  // Flags ride with float_out and hold until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else if (s1_vld_q) begin
      ovf_q     <= ovf_d;
      unf_q     <= unf_d & ~ovf_d;
      inexact_q <= s1_guard_q | s1_sticky_q;
    end
  end

  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign inexact = inexact_q;
`endif

endmodule

// File: doc/fp_mul_normalize_pipe.md
Name: fp_mul_normalize_pipe

Overview:
- Downstream stage of the FP multiply pipeline.
- Consumes the raw 48-bit mantissa product, the unbiased signed exponent sum and the pass-through operand from the multiply stage.
- Normalizes, rounds to nearest-even, re-biases and packs a 31-bit positive single-precision result (sign handled outside).
- Two-stage pipeline, no backpressure; feeds the next inverse-sqrt iteration stage.

Parameters:
- EXP_BIAS, 127, exponent bias added when packing the result.
- PASS_W, 31, width of the operand passed through alongside the result.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  M_mul/E_mul/float_in_2 are valid this cycle (driven by the multiply stage's ready).
- M_mul  input  48  unsigned product {1,M1}*{1,M2}; bit 47 or bit 46 is set for legal inputs.
- E_mul  input  8  signed unbiased exponent sum.
- float_in_2  input  PASS_W  operand to forward, aligned with the result.
- float_out  output  31  packed result {exp[7:0], mant[22:0]}.
- float_out_2  output  PASS_W  float_in_2 delayed to align with float_out.
- ready  output  1  one-cycle pulse, float_out/float_out_2 are valid.

Behaviour:
- Reset (async, rst_n=0):
  - float_out=0, float_out_2=0, ready=0.
  - All internal pipeline registers and stage-valid bits cleared.
  - Reset mid-operation discards in-flight data; no ready is produced for it.
- Latency: exactly 2 clk cycles from valid to ready. Throughput: one result per cycle; back-to-back valids are accepted every cycle.
- Stage 1 (on valid), normalize:
  - If M_mul[47]=1: mant=M_mul[46:24], guard=M_mul[23], sticky=|M_mul[22:0], e=sext10(E_mul)+1.
  - Else: mant=M_mul[45:23], guard=M_mul[22], sticky=|M_mul[21:0], e=sext10(E_mul).
  - Register mant, guard, sticky, e (10-bit signed) and float_in_2; set s1_vld.
- Stage 2 (on s1_vld), round and pack:
  - Round RNE: round_up = guard & (sticky | mant[0]).
  - {carry, mant_r} = mant + round_up (24-bit). If carry=1: mant_r=0 and e=e+1.
  - be = e + EXP_BIAS (10-bit signed).
  - be >= 255 → float_out = {8'hFF, 23'h0} (infinity).
  - be <= 0 → float_out = 0 (flush to zero, no denormals).
  - Otherwise → float_out = {be[7:0], mant_r}.
  - float_out_2 gets the stage-1 copy. ready=1 for this cycle only.
- When no stage-valid is set: float_out and float_out_2 hold their previous values; ready=0.
- M_mul with bits 47:46 = 00 (illegal input) is treated as the bit46 path; no error is flagged.

Optional Feature:
- Macro: FP_MUL_NORM_STATUS_EN.
- When defined, adds three outputs, each 1 bit, registered with float_out and cleared on reset, holding until the next ready:
  - ovf: saturated to infinity.
  - unf: flushed to zero.
  - inexact: guard|sticky before rounding.
- When not defined: ports absent; datapath behaviour identical.

Test Plan:
- 1.0*1.0: M_mul=48'h4000_0000_0000, E_mul=0, valid for 1 cycle → 2 cycles later ready=1, float_out=31'h3F80_0000.
- 1.5*1.5: M_mul=48'h9000_0000_0000, E_mul=0 → float_out=31'h4010_0000. float_in_2=31'h1234_5678 appears on float_out_2 in the same cycle.
- Rounding ties:
  - M_mul=48'h4000_00C0_0000 → 31'h3F80_0002 (tie, odd lsb, rounds up).
  - M_mul=48'h4000_0040_0000 → 31'h3F80_0000 (tie, even lsb, stays).
- Rounding carry: M_mul=48'h7FFF_FFC0_0000, E_mul=0 → mantissa wraps, float_out=31'h4000_0000.
- Saturation:
  - E_mul=127, M_mul=48'h8000_0000_0000 → 31'h7F80_0000 (ovf=1 if enabled).
  - E_mul=-127, M_mul=48'h4000_0000_0000 → 31'h0 (unf=1 if enabled).
- Streaming plus reset: 4 consecutive valids → 4 consecutive ready pulses in order. Asserting rst_n=0 with 2 in flight → no further ready, outputs 0 immediately.
